alu_md: RTL and testbench
=========================

# alu_md

Execute-stage multiply/divide unit with architectural HI/LO registers. Sits beside the E-stage ALU and consumes the same registered `aluopE` that the ALU decoder produces, plus the E-stage operands. It handles MULT/MULTU in one cycle, DIV/DIVU with an iterative radix-2 divider that stalls the pipeline, and MTHI/MTLO/MFHI/MFLO.

## Interface
Parameters:
- `DIV_CYCLES`, 32: number of divider iterations; must equal the operand width.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `aluopE`  in  8  E-stage ALU op code from the decoder's D→E register.
- `srcaE`  in  32  rs operand (forwarded); dividend / multiplicand / MTHI/MTLO source.
- `srcbE`  in  32  rt operand (forwarded); divisor / multiplier.
- `flushE`  in  1  kill the E-stage instruction, including any divide in progress.
- `stall_div`  out  1  hold F/D/E; the hazard unit ORs it into its stall terms.
- `mdresultE`  out  32  HI for MFHI, LO for MFLO, 0 otherwise.
- `hi_o`, `lo_o`  out  32 each  current HI/LO contents.

## Operation
- Decode from `aluopE`: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO. Every other code is a no-op for this block.
- MULT/MULTU: full 64-bit signed/unsigned product. {HI,LO} are written on the clock edge that ends the E cycle. No stall.
- MTHI/MTLO: write `srcaE` to HI/LO on the E-cycle edge.
- MFHI/MFLO: `mdresultE` is combinational from the HI/LO registers.
- DIV/DIVU FSM states are IDLE, BUSY and DONE.
  - IDLE→BUSY when a DIV/DIVU op is present and `flushE`=0. This edge latches the operand magnitudes (DIV: absolute values; DIVU: raw), the quotient sign (sa^sb) and the remainder sign (sa), and clears the iteration counter.
  - BUSY: one restoring shift-subtract step per cycle. BUSY→DONE after `DIV_CYCLES` iterations.
  - DONE: apply the sign fix. HI=remainder and LO=quotient are written on the DONE edge. DONE→IDLE.
- `stall_div` = ((IDLE & div op) | BUSY) & ~flushE. It is low in DONE, so the divide leaves E on the same edge that writes HI/LO.
- Divisor zero (DIV or DIVU): full latency, then LO=0xFFFFFFFF and HI=dividend, with no sign fix and no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000 and HI=0 (wrap, no trap).
- `flushE` in any state returns the FSM to IDLE on the next edge. It drops `stall_div` combinationally in the same cycle. HI/LO and all other writes are suppressed while `flushE`=1.
- Only one E-stage op exists per cycle, so simultaneous HI/LO writers cannot occur.

## Timing
- Reset values: HI=0, LO=0, FSM=IDLE, counter=0, `stall_div`=0, `mdresultE`=0.
- MULT/MTxx latency: 1 edge. The following instruction's MFHI/MFLO in E reads the new value with no bypass.
- DIV latency: counting the first E cycle of the divide as cycle 1:
  - `stall_div` is high in cycles 1–33.
  - DONE is cycle 34, with `stall_div` low.
  - HI/LO are valid from cycle 35.
- Asynchronous `rst` mid-divide: immediate return to the reset values above. The partial result is discarded.

## Structure
- The `instrdefines.vh` header holds the op codes for this block: `ALUOP_MULT`, `ALUOP_MULTU`, `ALUOP_DIV`, `ALUOP_DIVU`, `ALUOP_MTHI`, `ALUOP_MTLO`, `ALUOP_MFHI`, `ALUOP_MFLO`.
- The FSM state encodings are localparams in this module.
- Sub-module `div_radix2`: sign handling, iteration counter, remainder/quotient shift registers, and `start`/`cancel`/`done` handshake. `alu_md` owns HI/LO, the multiplier and the decode.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → HI=LO=0, `stall_div`=0, `mdresultE`=0 immediately.
- MULT 0xFFFFFFFE × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA after 1 edge. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA. `stall_div` never high.
- Signed and unsigned divides, each with `stall_div` high exactly 33 cycles:
  - DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 7 → LO=14, HI=2.
  - DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU 5 / 0 → after 34 cycles LO=0xFFFFFFFF, HI=5.
- Flush mid-divide: start a DIV with HI=LO=0x12345678, assert `flushE` in BUSY iteration 10 → `stall_div` low that cycle, FSM IDLE next cycle, HI/LO unchanged.
- Back-to-back ops:
  - DIVU 100 / 7 immediately followed by MFLO → `mdresultE`=14 in MFLO's E cycle.
  - MTHI 0xCAFEBABE followed by MFHI → `mdresultE`=0xCAFEBABE.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared op codes and decode for the E-stage multiply/divide unit.
// Op code values mirror the MIPS SPECIAL funct field used by the ALU decoder.
package alu_md_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] ALUOP_NOP   = 8'h00;
  localparam logic [7:0] ALUOP_MFHI  = 8'h10;
  localparam logic [7:0] ALUOP_MTHI  = 8'h11;
  localparam logic [7:0] ALUOP_MFLO  = 8'h12;
  localparam logic [7:0] ALUOP_MTLO  = 8'h13;
  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;
  localparam logic [7:0] ALUOP_DIV   = 8'h1A;
  localparam logic [7:0] ALUOP_DIVU  = 8'h1B;

  typedef struct packed {
    logic mult;
    logic multu;
    logic div;
    logic divu;
    logic mthi;
    logic mtlo;
    logic mfhi;
    logic mflo;
  } md_dec_t;

  function automatic md_dec_t md_decode(input logic [7:0] op);
    md_dec_t d;
    d = '0;
    case (op)
      ALUOP_MULT:  d.mult  = 1'b1;
      ALUOP_MULTU: d.multu = 1'b1;
      ALUOP_DIV:   d.div   = 1'b1;
      ALUOP_DIVU:  d.divu  = 1'b1;
      ALUOP_MTHI:  d.mthi  = 1'b1;
      ALUOP_MTLO:  d.mtlo  = 1'b1;
      ALUOP_MFHI:  d.mfhi  = 1'b1;
      ALUOP_MFLO:  d.mflo  = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_md_div_radix2.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle, with sign
// handling on entry and exit and a start/cancel/done handshake.
module div_radix2
  import alu_md_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cancel,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              idle,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem_p0, quo_p0, dvs_p0, raw_p0;
  logic              negq_p0, negr_p0, dvz_p0;
  logic [DATA_W:0]   shifted, diff;
  logic              fits;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic sgn);
    return (sgn && v < 0) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  assign shifted = {rem_p0, quo_p0[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_p0};
  assign fits    = ~diff[DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (cancel) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_BUSY;
          cnt   <= '0;
        end
        S_BUSY: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DIV_CYCLES - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // p0: operand capture on start, then one shift-subtract step per BUSY cycle
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      rem_p0  <= '0;
      quo_p0  <= mag(dividend, is_signed);
      dvs_p0  <= mag(divisor, is_signed);
      raw_p0  <= dividend;
      negq_p0 <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      negr_p0 <= is_signed & dividend[DATA_W-1];
      dvz_p0  <= (divisor == '0);
    end else if (state == S_BUSY) begin
      rem_p0 <= fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo_p0 <= {quo_p0[DATA_W-2:0], fits};
    end
  end

  assign idle      = (state == S_IDLE);
  assign busy      = (state == S_BUSY);
  assign done      = (state == S_DONE);
  // Divide-by-zero bypasses the sign fix: all-ones quotient, raw dividend remainder
  assign quotient  = dvz_p0 ? '1 : apply_sign(quo_p0, negq_p0);
  assign remainder = dvz_p0 ? raw_p0 : apply_sign(rem_p0, negr_p0);

endmodule

// File: rtl/alu_md.sv
// E-stage multiply/divide unit: owns HI/LO, the single-cycle multiplier and
// op decode; divides are delegated to div_radix2 and stall the pipeline.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluopE,
  input  logic [DATA_W-1:0] srcaE,
  input  logic [DATA_W-1:0] srcbE,
  input  logic              flushE,
  output logic              stall_div,
  output logic [DATA_W-1:0] mdresultE,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  md_dec_t                  dec;
  logic                     is_div;
  logic signed [2*DATA_W-1:0] sa_x, sb_x, prod_s;
  logic [2*DATA_W-1:0]      prod_u, prod;
  logic [DATA_W-1:0]        hi_reg, lo_reg;
  logic [DATA_W-1:0]        div_q, div_r;
  logic                     div_idle, div_busy, div_done;

  assign dec    = md_decode(aluopE);
  assign is_div = dec.div | dec.divu;

  assign sa_x   = {{DATA_W{srcaE[DATA_W-1]}}, srcaE};
  assign sb_x   = {{DATA_W{srcbE[DATA_W-1]}}, srcbE};
  assign prod_s = sa_x * sb_x;
  assign prod_u = {{DATA_W{1'b0}}, srcaE} * {{DATA_W{1'b0}}, srcbE};
  assign prod   = dec.mult ? $unsigned(prod_s) : prod_u;

  div_radix2 #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div & ~flushE),
    .cancel    (flushE),
    .is_signed (dec.div),
    .dividend  (srcaE),
    .divisor   (srcbE),
    .idle      (div_idle),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // DONE drops the stall so the divide leaves E on the edge that writes HI/LO
  assign stall_div = ((div_idle & is_div) | div_busy) & ~flushE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (!flushE) begin
      if (dec.mult | dec.multu) begin
        hi_reg <= prod[2*DATA_W-1:DATA_W];
        lo_reg <= prod[DATA_W-1:0];
      end else if (dec.mthi) begin
        hi_reg <= srcaE;
      end else if (dec.mtlo) begin
        lo_reg <= srcaE;
      end else if (div_done) begin
        hi_reg <= div_r;
        lo_reg <= div_q;
      end
    end
  end

  assign mdresultE = dec.mfhi ? hi_reg : (dec.mflo ? lo_reg : '0);
  assign hi_o      = hi_reg;
  assign lo_o      = lo_reg;

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: directed vector table, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_alu_md;
  import alu_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluopE;
  logic [31:0] srcaE, srcbE;
  logic        flushE;
  logic        stall_div;
  logic [31:0] mdresultE, hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_md #(.DIV_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .aluopE    (aluopE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .flushE    (flushE),
    .stall_div (stall_div),
    .mdresultE (mdresultE),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b, hi, lo;
    int          stalls;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one op in E and holds it until the unit stops stalling, then
  // passes the edge that retires it. Returns with inputs at NOP, #1 after that edge.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    bit fin;
    fin = 1'b0;
    stalls = 0;
    aluopE = op; srcaE = a; srcbE = b;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (stall_div) stalls++;
      else fin = 1'b1;
      @(posedge clk); #1;
    end
    aluopE = ALUOP_NOP;
    check("op_completes", {31'b0, fin}, 32'd1);
  endtask

  function automatic void ref_md(input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo, output int stalls);
    int signed sa, sb;
    longint signed p;
    longint unsigned pu, au, bu;
    sa = a; sb = b;
    hi = 0; lo = 0; stalls = 0;
    case (op)
      ALUOP_MULT: begin
        p = longint'(sa) * longint'(sb);
        hi = p[63:32]; lo = p[31:0];
      end
      ALUOP_MULTU: begin
        au = a; bu = b; pu = au * bu;
        hi = pu[63:32]; lo = pu[31:0];
      end
      default: begin
        stalls = 33;
        if (b == 0) begin
          lo = 32'hFFFFFFFF; hi = a;
        end else if (op == ALUOP_DIVU) begin
          lo = a / b; hi = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          lo = 32'h80000000; hi = 0;
        end else begin
          lo = sa / sb; hi = sa % sb;
        end
      end
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    logic [31:0] ehi, elo;
    int est;
    logic [7:0] rops [4];

    vecs[0]  = '{ALUOP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0};
    vecs[1]  = '{ALUOP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 0};
    vecs[2]  = '{ALUOP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{ALUOP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[4]  = '{ALUOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5]  = '{ALUOP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
    vecs[6]  = '{ALUOP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    vecs[7]  = '{ALUOP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[8]  = '{ALUOP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0};
    vecs[9]  = '{ALUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0};
    vecs[10] = '{ALUOP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};
    vecs[11] = '{ALUOP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       33};

    rst = 1'b1; aluopE = ALUOP_NOP; srcaE = 0; srcbE = 0; flushE = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("reset_hi", hi_o, 0);
    check("reset_lo", lo_o, 0);
    check("reset_stall", {31'b0, stall_div}, 0);
    check("reset_mdresult", mdresultE, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, st);
      check($sformatf("vec%0d_hi", i), hi_o, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo_o, vecs[i].lo);
      check($sformatf("vec%0d_stalls", i), st, vecs[i].stalls);
      aluopE = ALUOP_MFLO;
      @(negedge clk);
      check($sformatf("vec%0d_mflo", i), mdresultE, vecs[i].lo);
      @(posedge clk); #1;
      aluopE = ALUOP_NOP;
    end

    run_op(ALUOP_MTHI, 32'hCAFEBABE, 32'h0, st);
    check("mthi_stalls", st, 0);
    aluopE = ALUOP_MFHI;
    @(negedge clk);
    check("mthi_mfhi", mdresultE, 32'hCAFEBABE);
    @(posedge clk); #1;
    run_op(ALUOP_MTLO, 32'h0BADF00D, 32'h0, st);
    aluopE = ALUOP_MFLO;
    @(negedge clk);
    check("mtlo_mflo", mdresultE, 32'h0BADF00D);
    check("mtlo_keeps_hi", hi_o, 32'hCAFEBABE);
    @(posedge clk); #1;
    aluopE = ALUOP_NOP;
    @(negedge clk);
    check("nop_mdresult", mdresultE, 0);
    @(posedge clk); #1;

    // Flush in the tenth BUSY iteration
    run_op(ALUOP_MTHI, 32'h12345678, 32'h0, st);
    run_op(ALUOP_MTLO, 32'h12345678, 32'h0, st);
    aluopE = ALUOP_DIV; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    check("stall_before_flush", {31'b0, stall_div}, 1);
    flushE = 1'b1;
    #1;
    check("stall_during_flush", {31'b0, stall_div}, 0);
    @(posedge clk); #1;
    flushE = 1'b0; aluopE = ALUOP_NOP;
    @(negedge clk);
    check("idle_after_flush", {31'b0, stall_div}, 0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi", hi_o, 32'h12345678);
    check("flush_lo", lo_o, 32'h12345678);

    aluopE = ALUOP_MULT; srcaE = 32'd9; srcbE = 32'd9; flushE = 1'b1;
    @(posedge clk); #1;
    flushE = 1'b0; aluopE = ALUOP_NOP;
    check("flushed_mult_lo", lo_o, 32'h12345678);

    // Asynchronous reset in the middle of a divide
    aluopE = ALUOP_DIVU; srcaE = 32'd100; srcbE = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    aluopE = ALUOP_MFHI;
    rst = 1'b1;
    #1;
    check("arst_hi", hi_o, 0);
    check("arst_lo", lo_o, 0);
    check("arst_stall", {31'b0, stall_div}, 0);
    check("arst_mdresult", mdresultE, 0);
    @(posedge clk); #3;
    rst = 1'b0; aluopE = ALUOP_NOP;
    @(negedge clk);
    check("post_arst_stall", {31'b0, stall_div}, 0);
    @(posedge clk); #1;

    rops[0] = ALUOP_MULT; rops[1] = ALUOP_MULTU; rops[2] = ALUOP_DIV; rops[3] = ALUOP_DIVU;
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      op = rops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 20);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      ref_md(op, a, b, ehi, elo, est);
      run_op(op, a, b, st);
      check($sformatf("rand%0d_op%02h_hi a=%08h b=%08h", i, op, a, b), hi_o, ehi);
      check($sformatf("rand%0d_op%02h_lo a=%08h b=%08h", i, op, a, b), lo_o, elo);
      check($sformatf("rand%0d_stalls", i), st, est);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
